// File: rtl/uart_pkg.sv
// Shared UART definitions: clock/baud defaults, bit-period helper and FSM states
// used by uart_tx, uart_recv and uart_tx_buf.
package uart_pkg;

  localparam int CLK_FREQ_DEF = 50_000_000;
  localparam int UART_BPS_DEF = 115_200;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  function automatic int bps_cnt(input int clk_freq, input int uart_bps);
    return clk_freq / uart_bps;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous byte FIFO with exact occupancy count; push is ignored when full,
// pop is ignored when empty, and a simultaneous push/pop leaves the level unchanged.
module uart_fifo import uart_pkg::*; #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic [4:0] level,
  output logic       full,
  output logic       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == 5'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by natural overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 5'd1;
      else if (do_pop && !do_push) level <= level - 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered 8N1 UART transmitter: bytes queue in uart_fifo and are sent
// back-to-back by a baud-timed START/DATA/STOP state machine.
module uart_tx_buf import uart_pkg::*; #(
  parameter int CLK_FREQ   = CLK_FREQ_DEF,
  parameter int UART_BPS   = UART_BPS_DEF,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_din,
  output logic       tx_ready,
  output logic       tx_dout,
  output logic       tx_busy,
  output logic [4:0] fifo_level
);

  localparam int BPS_CNT = bps_cnt(CLK_FREQ, UART_BPS);
  localparam int CW      = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BPS_CNT - 1);

  uart_state_t   state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;
  logic [7:0]    head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          bit_end;
  logic          pop;

  assign bit_end  = (baud_cnt == CNT_MAX);
  assign pop      = !fifo_empty && ((state == IDLE) || (state == STOP && bit_end));
  assign tx_ready = !fifo_full;

  uart_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .push  (tx_valid),
    .din   (tx_din),
    .pop   (pop),
    .dout  (head),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      tx_dout   <= 1'b1;
      tx_busy   <= 1'b0;
    end else begin
      // The line register follows the state one cycle later, so every bit
      // still lasts BPS_CNT cycles but starts a cycle after its state.
      case (state)
        IDLE:    tx_dout <= 1'b1;
        START:   tx_dout <= 1'b0;
        DATA:    tx_dout <= shift_reg[bit_idx];
        STOP:    tx_dout <= 1'b1;
        default: tx_dout <= 1'b1;
      endcase

      case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_idx  <= '0;
          if (pop) begin
            shift_reg <= head;
            state     <= START;
            tx_busy   <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (pop) begin
              shift_reg <= head;
              state     <= START;
            end else begin
              state   <= IDLE;
              tx_busy <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Scoreboarded bench for uart_tx_buf: a line monitor decodes frames and pops
// expected bytes queued when they were pushed; scenario tasks add timing checks.
module tb_uart_tx_buf;

  localparam int BPS   = 434;
  localparam int FRAME = 10 * BPS;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       tx_valid  = 1'b0;
  logic [7:0] tx_din    = '0;
  logic       tx_ready;
  logic       tx_dout;
  logic       tx_busy;
  logic [4:0] fifo_level;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q [$];
  bit         mon_en = 1'b0;
  logic [7:0] mon_byte;
  logic [7:0] mon_exp;
  logic       mon_start_ok;
  logic       mon_stop;

  uart_tx_buf #(
    .CLK_FREQ   (50_000_000),
    .UART_BPS   (115_200),
    .FIFO_DEPTH (8)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .tx_valid   (tx_valid),
    .tx_din     (tx_din),
    .tx_ready   (tx_ready),
    .tx_dout    (tx_dout),
    .tx_busy    (tx_busy),
    .fifo_level (fifo_level)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic frame_bit(input int off, input logic [7:0] b);
    int idx;
    idx = off / BPS;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    return 1'b1;
  endfunction

  // Line monitor: mid-bit sampling, compare against scoreboard head
  initial begin : monitor
    forever begin
      @(negedge sys_clk);
      if (mon_en && sys_rst_n && tx_dout === 1'b0) begin
        repeat (BPS / 2) @(negedge sys_clk);
        mon_start_ok = (tx_dout === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (BPS) @(negedge sys_clk);
          mon_byte[i] = tx_dout;
        end
        repeat (BPS) @(negedge sys_clk);
        mon_stop = tx_dout;
        if (mon_en) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL rx_unexpected: got frame byte %02h, none expected", mon_byte);
          end else begin
            mon_exp = exp_q.pop_front();
            if (!mon_start_ok || mon_stop !== 1'b1 || mon_byte !== mon_exp) begin
              n_fail++;
              $display("FAIL rx_byte: got %02h start_ok=%b stop=%b, want %02h start_ok=1 stop=1",
                       mon_byte, mon_start_ok, mon_stop, mon_exp);
            end
          end
        end
      end
    end
  end

  task automatic wait_idle(input int budget, input string name);
    int c;
    c = 0;
    while ((tx_busy !== 1'b0 || exp_q.size() != 0) && c < budget) begin
      @(negedge sys_clk);
      c++;
    end
    repeat (BPS) @(negedge sys_clk);
    n_checks++;
    if (c >= budget) begin
      n_fail++;
      $display("FAIL %s_drain: busy=%b pending=%0d after %0d cycles, want busy=0 pending=0",
               name, tx_busy, exp_q.size(), c);
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    tx_valid  = 1'b1;
    tx_din    = 8'hC3;
    repeat (3) @(negedge sys_clk);
    n_checks++;
    if (tx_dout !== 1'b1) begin n_fail++; $display("FAIL reset_dout: got %b want 1", tx_dout); end
    n_checks++;
    if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
    n_checks++;
    if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", tx_ready); end
    n_checks++;
    if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    tx_valid  = 1'b0;
    sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    n_checks++;
    if (fifo_level !== 5'd0 || tx_busy !== 1'b0 || tx_dout !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: level=%0d busy=%b dout=%b want 0/0/1", fifo_level, tx_busy, tx_dout);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_single();
    int   bad_line, bad_busy, first_line;
    logic exp_l, exp_b;
    bad_line = 0; bad_busy = 0; first_line = -1;
    @(negedge sys_clk);
    tx_valid = 1'b1;
    tx_din   = 8'h55;
    n_checks++;
    if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b want 1", tx_ready); end
    exp_q.push_back(8'h55);
    @(posedge sys_clk);
    for (int k = 1; k <= FRAME + 6; k++) begin
      @(negedge sys_clk);
      if (k == 1) begin
        tx_valid = 1'b0;
        n_checks++;
        if (fifo_level !== 5'd1) begin n_fail++; $display("FAIL single_level_push: got %0d want 1", fifo_level); end
      end
      if (k == 2) begin
        n_checks++;
        if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL single_level_pop: got %0d want 0", fifo_level); end
      end
      exp_l = (k < 3) ? 1'b1 : (k < 3 + FRAME) ? frame_bit(k - 3, 8'h55) : 1'b1;
      exp_b = (k >= 2 && k < 2 + FRAME);
      if (tx_dout !== exp_l) begin
        bad_line++;
        if (first_line < 0) first_line = k;
      end
      if (tx_busy !== exp_b) bad_busy++;
    end
    n_checks++;
    if (bad_line != 0) begin
      n_fail++;
      $display("FAIL single_line: %0d cycles off, first at cycle %0d after push, want 0", bad_line, first_line);
    end
    n_checks++;
    if (bad_busy != 0) begin
      n_fail++;
      $display("FAIL single_busy: %0d cycles off, want 0", bad_busy);
    end
    wait_idle(FRAME, "single");
  endtask

  task automatic test_back_to_back();
    int   bad_line, first_line;
    logic exp_l;
    bad_line = 0; first_line = -1;
    @(negedge sys_clk);
    tx_valid = 1'b1;
    tx_din   = 8'h00;
    exp_q.push_back(8'h00);
    @(posedge sys_clk);
    for (int k = 1; k <= 2 * FRAME + 6; k++) begin
      @(negedge sys_clk);
      if (k == 1) begin
        n_checks++;
        if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b want 1", tx_ready); end
        tx_din = 8'hFF;
        exp_q.push_back(8'hFF);
      end
      if (k == 2) begin
        tx_valid = 1'b0;
        n_checks++;
        if (fifo_level !== 5'd1) begin n_fail++; $display("FAIL b2b_level_pushpop: got %0d want 1", fifo_level); end
      end
      if (k == FRAME + 2) begin
        n_checks++;
        if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL b2b_level_second_pop: got %0d want 0", fifo_level); end
      end
      exp_l = (k < 3)             ? 1'b1 :
              (k < 3 + FRAME)     ? frame_bit(k - 3, 8'h00) :
              (k < 3 + 2 * FRAME) ? frame_bit(k - 3 - FRAME, 8'hFF) : 1'b1;
      if (tx_dout !== exp_l) begin
        bad_line++;
        if (first_line < 0) first_line = k;
      end
      if (k > 2 && k < 2 + 2 * FRAME && tx_busy !== 1'b1) begin
        bad_line++;
        if (first_line < 0) first_line = k;
      end
    end
    n_checks++;
    if (bad_line != 0) begin
      n_fail++;
      $display("FAIL b2b_line: %0d cycles off, first at cycle %0d after push, want 0", bad_line, first_line);
    end
    wait_idle(FRAME, "b2b");
  endtask

  task automatic test_stream_full();
    logic [7:0] bytes [10];
    int         idx, cyc, bad_ready;
    logic [4:0] prev_level;
    logic       prev_ready;
    bit         saw_full, saw_release;
    bytes = '{8'h3A, 8'hC5, 8'h01, 8'h80, 8'h7E, 8'hE7, 8'h5A, 8'h96, 8'h2D, 8'hF0};
    idx = 0; cyc = 0; bad_ready = 0;
    prev_level = '0; prev_ready = 1'b1; saw_full = 1'b0; saw_release = 1'b0;
    @(negedge sys_clk);
    tx_valid = 1'b1;
    tx_din   = bytes[0];
    while (idx < 10 && cyc < 3 * FRAME) begin
      if (tx_ready !== (fifo_level != 5'd8)) bad_ready++;
      if (fifo_level == 5'd8) saw_full = 1'b1;
      if (prev_level == 5'd8 && fifo_level != 5'd8 && !saw_release) begin
        saw_release = 1'b1;
        n_checks++;
        if (fifo_level !== 5'd7 || tx_ready !== 1'b1 || prev_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL full_pop: level=%0d ready=%b prev_ready=%b, want 7/1/0", fifo_level, tx_ready, prev_ready);
        end
      end
      prev_level = fifo_level;
      prev_ready = tx_ready;
      if (tx_ready === 1'b1) begin
        @(posedge sys_clk);
        exp_q.push_back(bytes[idx]);
        idx++;
      end else begin
        @(posedge sys_clk);
      end
      @(negedge sys_clk);
      cyc++;
      if (idx < 10) tx_din = bytes[idx];
      else          tx_valid = 1'b0;
    end
    tx_valid = 1'b0;
    n_checks++;
    if (idx != 10) begin n_fail++; $display("FAIL stream_accept: accepted %0d bytes want 10", idx); end
    n_checks++;
    if (!saw_full || !saw_release) begin
      n_fail++;
      $display("FAIL stream_full_seen: full=%b release=%b want 1/1", saw_full, saw_release);
    end
    n_checks++;
    if (bad_ready != 0) begin
      n_fail++;
      $display("FAIL stream_ready: %0d cycles where ready != (level!=8), want 0", bad_ready);
    end
    wait_idle(11 * FRAME, "stream");
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    bad = 0;
    mon_en = 1'b0;
    @(negedge sys_clk);
    tx_valid = 1'b1;
    tx_din   = 8'hA5;
    @(posedge sys_clk);
    @(negedge sys_clk); tx_din = 8'h11;
    @(posedge sys_clk);
    @(negedge sys_clk); tx_din = 8'h22;
    @(posedge sys_clk);
    @(negedge sys_clk); tx_din = 8'h33;
    @(posedge sys_clk);
    @(negedge sys_clk); tx_valid = 1'b0;
    // cycle 1000 after the first push falls in data bit 1 of 0xA5, a 0
    repeat (996) @(negedge sys_clk);
    n_checks++;
    if (fifo_level !== 5'd3 || tx_dout !== 1'b0 || tx_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_pre: level=%0d dout=%b busy=%b want 3/0/1", fifo_level, tx_dout, tx_busy);
    end
    #2 sys_rst_n = 1'b0;
    #1;
    n_checks++;
    if (tx_dout !== 1'b1 || fifo_level !== 5'd0 || tx_busy !== 1'b0 || tx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_async: dout=%b level=%0d busy=%b ready=%b want 1/0/0/1",
               tx_dout, fifo_level, tx_busy, tx_ready);
    end
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    mon_en    = 1'b1;
    repeat (FRAME) begin
      @(negedge sys_clk);
      if (tx_dout !== 1'b1 || tx_busy !== 1'b0 || fifo_level !== 5'd0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL rst_mid_quiet: %0d cycles not idle after release, want 0", bad);
    end
    tx_valid = 1'b1;
    tx_din   = 8'h3C;
    exp_q.push_back(8'h3C);
    @(posedge sys_clk);
    @(negedge sys_clk);
    tx_valid = 1'b0;
    wait_idle(2 * FRAME, "rst_mid");
  endtask

  initial begin : watchdog
    #(1_500_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    test_reset();
    test_single();
    test_back_to_back();
    test_stream_full();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
